// File: rtl/rvfi_trace_buffer.sv
// Buffers RVFI retirement records in a DEPTH-entry FIFO and streams each one out
// as four 32-bit words, tracking fill level, overflow drops and retirement-order gaps.
module rvfi_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       rvfi_valid_i,
  input  logic [63:0]                rvfi_order_i,
  input  logic [31:0]                rvfi_insn_i,
  input  logic [31:0]                rvfi_pc_rdata_i,
  input  logic [4:0]                 rvfi_rd_addr_i,
  input  logic [31:0]                rvfi_rd_wdata_i,
  input  logic                       rvfi_trap_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_data_o,
  output logic                       out_last_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [15:0]                dropped_count_o,
  output logic                       order_error_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [15:0] order;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
  } rec_t;

  rec_t          mem_q [DEPTH];
  rec_t          head, wr_rec;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    widx_q;
  logic          seen_q;
  logic [15:0]   prev_q;
  logic [15:0]   drop_q;
  logic          err_q;
  logic          full, push, drop, hs, pop;

  // Push/drop decisions look only at the level registered at the start of the cycle.
  assign full   = (level_q == LW'(DEPTH));
  assign push   = rvfi_valid_i && !full;
  assign drop   = rvfi_valid_i && full;
  assign hs     = out_valid_o && out_ready_i;
  assign pop    = hs && (widx_q == 2'd3);
  assign wr_rec = '{order: rvfi_order_i[15:0], trap: rvfi_trap_i, rd_addr: rvfi_rd_addr_i,
                    pc: rvfi_pc_rdata_i, insn: rvfi_insn_i, rd_wdata: rvfi_rd_wdata_i};
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    out_data_o = head.rd_wdata;
    case (widx_q)
      2'd0:    out_data_o = {head.order, 10'b0, head.trap, head.rd_addr};
      2'd1:    out_data_o = head.pc;
      2'd2:    out_data_o = head.insn;
      default: out_data_o = head.rd_wdata;
    endcase
  end

  assign out_valid_o     = (level_q != '0);
  assign out_last_o      = out_valid_o && (widx_q == 2'd3);
  assign level_o         = level_q;
  assign dropped_count_o = drop_q;
  assign order_error_o   = err_q;

  // Storage needs no reset: the pointers and level define what is live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_rec;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      widx_q   <= '0;
      seen_q   <= 1'b0;
      prev_q   <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        seen_q   <= 1'b1;
        prev_q   <= rvfi_order_i[15:0];
        if (seen_q && (rvfi_order_i[15:0] != prev_q + 16'd1)) err_q <= 1'b1;
      end
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (hs) widx_q <= widx_q + 2'd1;
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end
endmodule
